// File: rtl/sample_counter.sv
// sample_counter: edge/level event counter with a programmable terminal count.
// The counter either wraps to zero with a rollover pulse or saturates at the threshold.
module sample_counter #(
  parameter int NUM_BITS  = 10,
  parameter int EDGE_MODE = 1,
  parameter int WRAP_MODE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                count_up,
  input  logic [NUM_BITS-1:0] threshold,
  output logic [NUM_BITS-1:0] count_out,
  output logic                thresh_flag,
  output logic                rollover_flag,
  output logic                saturated
);

  logic                cu_q;
  logic                evt;
  logic [NUM_BITS-1:0] inc;
  logic [NUM_BITS-1:0] cnt_d;
  logic                roll_d;
  logic                sat_d;

  assign evt = (EDGE_MODE != 0) ? (count_up & ~cu_q)
                                : count_up;

  assign inc = count_out + NUM_BITS'(1);

  assign thresh_flag = (count_out >= threshold);

  // next count, rollover pulse and saturation state for an un-cleared edge
  always_comb begin
    cnt_d  = count_out;
    roll_d = 1'b0;
    sat_d  = saturated;
    if (WRAP_MODE != 0) begin
      sat_d = 1'b0;
      if (evt) begin
        if (count_out == threshold) begin
          cnt_d  = '0;
          roll_d = 1'b1;
        end else begin
          // above a lowered threshold: free-run to the natural wrap
          cnt_d  = inc;
          roll_d = (inc == '0);
        end
      end
    end else begin
      if (evt && (count_out < threshold)) begin
        cnt_d = inc;
      end else if (evt) begin
        sat_d = 1'b1;
      end
      if (threshold > count_out) begin
        sat_d = 1'b0;
      end
    end
  end

  // state register: reset, then clear, then the computed update
  always_ff @(posedge clk) begin
    if (reset) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      saturated     <= 1'b0;
      cu_q          <= 1'b1;
    end else begin
      cu_q <= count_up;
      if (clear) begin
        count_out     <= '0;
        rollover_flag <= 1'b0;
        saturated     <= 1'b0;
      end else begin
        count_out     <= cnt_d;
        rollover_flag <= roll_d;
        saturated     <= sat_d;
      end
    end
  end

endmodule

// File: doc/sample_counter.md
SAMPLE_COUNTER -- requirements
Module: sample_counter

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 10, which sets the counter and threshold width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter EDGE_MODE, default 1: 1 = one count per rising edge of count_up; 0 = one count per clock while count_up is high.
REQ-003 The block SHALL have parameter WRAP_MODE, default 1: 1 = roll over to 0 after the threshold; 0 = saturate at the threshold.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous counter clear.
REQ-007 The block SHALL have port count_up, input, 1 bit: sample strobe or level.
REQ-008 The block SHALL have port threshold, input, NUM_BITS: terminal count value, sampled every cycle.
REQ-009 The block SHALL have port count_out, output, NUM_BITS: current registered count.
REQ-010 The block SHALL have port thresh_flag, output, 1 bit: high while count_out >= threshold.
REQ-011 The block SHALL have port rollover_flag, output, 1 bit: registered one-cycle pulse on every wrap to 0.
REQ-012 The block SHALL have port saturated, output, 1 bit: registered; high while a WRAP_MODE=0 counter is holding at its limit.

Function
REQ-013 Internal register cu_q SHALL hold count_up from the previous cycle.
- event = count_up & ~cu_q when EDGE_MODE=1.
- event = count_up when EDGE_MODE=0.
REQ-014 count_out SHALL update on the same clk edge at which the event is sampled, so the new value is visible one cycle after count_up is first sampled high.
REQ-015 Update priority per edge SHALL be: reset, then clear, then event, then hold.
REQ-016 WRAP_MODE=1, event with count_out == threshold: count_out SHALL become 0 and rollover_flag SHALL be 1 in the next cycle.
REQ-017 WRAP_MODE=1, event with count_out > threshold (threshold lowered mid-count): count_out SHALL increment modulo 2^NUM_BITS, and rollover_flag SHALL pulse only on the natural wrap to 0.
REQ-018 WRAP_MODE=1, event with count_out < threshold: count_out SHALL become count_out+1.
REQ-019 WRAP_MODE=0, event with count_out < threshold: count_out SHALL increment; otherwise count_out SHALL hold and saturated SHALL be set.
REQ-020 saturated SHALL clear only on clear, on reset, or when threshold is raised above count_out; in that last case it SHALL deassert on the next edge.
REQ-021 rollover_flag SHALL be 0 in every cycle not immediately following a wrap, and SHALL never stay high for two consecutive cycles unless two consecutive wraps occur (EDGE_MODE=0 with threshold = 0).
REQ-022 thresh_flag SHALL be combinational: (count_out >= threshold), unsigned compare at NUM_BITS width.
REQ-023 threshold = 0 SHALL be legal.
- WRAP_MODE=1: every event produces count_out = 0 plus a rollover pulse.
- WRAP_MODE=0: saturated goes high on the first event.
REQ-024 clear SHALL force count_out = 0, rollover_flag = 0 and saturated = 0, and SHALL discard any simultaneous event; cu_q SHALL still update.
REQ-025 Arithmetic SHALL be unsigned NUM_BITS wide with no carry-out port.

Reset
REQ-026 On reset high at a clk edge, the block SHALL set count_out = 0, rollover_flag = 0, saturated = 0 and cu_q = 1.
REQ-027 Because cu_q resets to 1, a count_up already high at reset release SHALL NOT count in EDGE_MODE=1; it SHALL count from the first cycle after release in EDGE_MODE=0.
REQ-028 Reset asserted mid-count SHALL override clear and any event in that cycle.

Verification
REQ-029 Edge count: NUM_BITS=10, EDGE_MODE=1, threshold=1000, 1000 single-cycle count_up pulses spaced 3 cycles apart -> count_out=1000 and thresh_flag=1; the 1001st pulse -> count_out=0 and rollover_flag high for exactly 1 cycle.
REQ-030 Level vs edge: count_up held high for 8 cycles -> count_out=1 with EDGE_MODE=1 and count_out=8 with EDGE_MODE=0.
REQ-031 Saturate: WRAP_MODE=0, threshold=5, 9 events -> count_out=5, saturated=1, rollover_flag never asserted; then raise threshold to 7 plus 1 event -> saturated=0, count_out=6.
REQ-032 Simultaneous: clear and event in the same cycle at count_out=3 -> count_out=0 next cycle; reset asserted with clear and event at count_out=4 -> all outputs 0.
REQ-033 Threshold lowered: WRAP_MODE=1, NUM_BITS=4, count_out=9, threshold changed to 3 -> thresh_flag=1 immediately; 7 events -> count_out=0 with a single rollover pulse.
REQ-034 Reset release: count_up high through reset deassertion, EDGE_MODE=1 -> count_out stays 0 until count_up falls and rises again.
